seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
- Parametrised multi-channel seven-segment display driver.
- Selects one of CHANNELS binary inputs and converts it to BCD with a sequential double-dabble engine.
- Blanks leading zeros, flags overflow, and time-multiplexes DIGITS anodes/cathodes.
- Sits between the measurement datapath (e.g. Celsius/Fahrenheit values) and the board display pins.

Parameters:
- DIGITS, 4: number of display digits/anodes (1..8).
- IN_W, 10: width of each input channel.
- CHANNELS, 2: number of selectable input channels (>=1).
- REFRESH_DIV, 50000: clock cycles each digit is lit (>=2).
- ACTIVE_LOW, 1: 1 = anode and cathode outputs active-low; 0 = active-high.
- BLANK_LZ, 1: 1 = blank leading zeros.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-high reset.
- data_in, input, CHANNELS*IN_W: packed channels; channel k = data_in[k*IN_W +: IN_W].
- sel, input, max(1,$clog2(CHANNELS)): channel select; out-of-range value selects channel 0.
- dp_mask, input, DIGITS: decimal point enable per digit.
- busy, output, 1: converter not in IDLE.
- conv_done, output, 1: one-cycle pulse when the display register updates.
- ovf, output, 1: last completed conversion overflowed.
- anod, output, DIGITS: digit enables; anod[0] = rightmost/least-significant digit.
- cat, output, 8: {dp,g,f,e,d,c,b,a}.

Behaviour:
- Reset (async, active-high):
  - anod and cat all inactive (all 1 when ACTIVE_LOW).
  - busy=0, conv_done=0, ovf=0.
  - Display register = 0; scan index 0; prescaler 0; converter in IDLE.
  - Reset mid-conversion discards the partial result.
- Converter FSM, states IDLE, SHIFT, DONE:
  - IDLE: every cycle, capture the selected channel into the shift register, clear the BCD field, go to SHIFT.
  - SHIFT: exactly IN_W cycles. Each cycle, add 3 to every BCD nibble >=5, then shift left 1. Bit counter 0..IN_W-1.
  - DONE: one cycle. Copy BCD nibbles and the overflow flag into the display register atomically; pulse conv_done; return to IDLE.
  - Latency from capture to visible update: IN_W+2 cycles. Conversions repeat back-to-back, so the period is IN_W+2 cycles.
  - sel or data_in changes during SHIFT do not affect the current conversion; the next capture takes them.
  - busy=1 in SHIFT and DONE.
- Overflow:
  - Captured value >= 10**DIGITS sets the overflow flag (constant comparison at capture).
  - On DONE with overflow, every digit displays a dash (segment g only) and ovf=1.
  - ovf clears on the next non-overflow DONE.
- Leading-zero blanking (BLANK_LZ=1):
  - Blank every digit above the most-significant nonzero nibble.
  - Digit 0 is never blanked, so value 0 shows a single "0".
  - Blanking never applies in overflow mode.
- Decimal point: dp driven from dp_mask[index], including on blanked digits.
- Scan:
  - Prescaler counts 0..REFRESH_DIV-1.
  - At terminal count the prescaler returns to 0 and the index increments, wrapping DIGITS-1 -> 0.
  - Exactly one anod bit active from the first clock after reset release.
  - anod and cat are registered and change on the same edge, so there is no ghosting between digits.
- Polarity: ACTIVE_LOW inverts both anod and cat at the output registers only.

Decomposition:
- Package seg7_pkg holds:
  - segment constants SEG_0..SEG_9, SEG_BLANK, SEG_DASH (active-high, g..a);
  - function nibble_to_seg;
  - function pow10(n) used for the overflow limit;
  - the converter state enum.
- Sub-module bcd_dabble_seq (parameters IN_W, DIGITS):
  - contains the SHIFT/DONE FSM;
  - handshake: start/value in, done/bcd/ovf out.
- Top level holds the channel mux, display register, blanking logic and scan counter.

Test Plan:
- Reset check: assert reset mid-SHIFT -> anod=4'b1111, cat=8'hFF immediately, busy=0. After release, anod=4'b1110 on the first edge.
- Full-scale value, defaults: data_in ch0=1023, sel=0 -> conv_done 12 cycles after capture; digits 3..0 show 1,0,2,3; ovf=0.
- Blanking: value 7 -> digits 3..1 SEG_BLANK, digit 0 SEG_7. Value 0 -> only digit 0 lit with SEG_0. Same values with BLANK_LZ=0 show zeros in all digits.
- Overflow: DIGITS=3, value 1000 -> all digits SEG_DASH, ovf=1. Then value 999 -> 9,9,9 and ovf=0.
- Channel switch: ch0=250, ch1=482; toggle sel from 0 to 1 during SHIFT -> next conv_done shows 250, the following one shows 482.
- Scan: REFRESH_DIV=4 -> anod rotates 1110, 1101, 1011, 0111, 1110, each held exactly 4 cycles. dp_mask=4'b0100 -> dp active only while anod=1011.

Source files
------------

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - segment encodings, digit helpers and converter state type
package seg7_pkg;

  // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_DASH  = 7'h40;

  typedef enum logic [1:0] {
    CONV_IDLE,
    CONV_SHIFT,
    CONV_DONE
  } conv_state_e;

  function automatic logic [6:0] nibble_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

endpackage

// File: rtl/bcd_dabble_seq.sv
// rtl/bcd_dabble_seq.sv - sequential double-dabble binary to BCD converter
module bcd_dabble_seq
  import seg7_pkg::*;
#(
  parameter int IN_W   = 10,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [IN_W-1:0]       value_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [4*DIGITS-1:0]   bcd_o,
  output logic                  ovf_o
);

  localparam int          CNT_W     = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam logic [63:0] OVF_LIMIT = pow10(DIGITS);

  conv_state_e           state_q, state_d;
  logic [IN_W-1:0]       bin_q, bin_d;
  logic [4*DIGITS-1:0]   bcd_q, bcd_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;

  // Only DIGITS nibbles are kept; overflowed values are shown as dashes anyway
  function automatic logic [4*DIGITS-1:0] dabble_adjust(input logic [4*DIGITS-1:0] b);
    logic [4*DIGITS-1:0] r;
    r = b;
    for (int i = 0; i < DIGITS; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      CONV_IDLE: begin
        if (start_i) begin
          bin_d   = value_i;
          bcd_d   = '0;
          cnt_d   = '0;
          ovf_d   = (64'(value_i) >= OVF_LIMIT);
          state_d = CONV_SHIFT;
        end
      end
      CONV_SHIFT: begin
        {bcd_d, bin_d} = {dabble_adjust(bcd_q), bin_q} << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(IN_W - 1)) state_d = CONV_DONE;
      end
      CONV_DONE: state_d = CONV_IDLE;
      default:   state_d = CONV_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= CONV_IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy_o = (state_q != CONV_IDLE);
  assign done_o = (state_q == CONV_DONE);
  assign bcd_o  = bcd_q;
  assign ovf_o  = ovf_q;

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - channel mux, display register, blanking and digit scan
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int IN_W        = 10,
  parameter int CHANNELS    = 2,
  parameter int REFRESH_DIV = 50000,
  parameter int ACTIVE_LOW  = 1,
  parameter int BLANK_LZ    = 1
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [CHANNELS*IN_W-1:0]                      data_in,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] sel,
  input  logic [DIGITS-1:0]                             dp_mask,
  output logic                                          busy,
  output logic                                          conv_done,
  output logic                                          ovf,
  output logic [DIGITS-1:0]                             anod,
  output logic [7:0]                                    cat
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PRE_W = $clog2(REFRESH_DIV);
  localparam logic [DIGITS-1:0] ANOD_INV = {DIGITS{ACTIVE_LOW != 0}};
  localparam logic [7:0]        CAT_INV  = {8{ACTIVE_LOW != 0}};

  logic [IN_W-1:0]       chan_val;
  logic                  dab_busy, dab_done, dab_ovf;
  logic [4*DIGITS-1:0]   dab_bcd;
  logic [4*DIGITS-1:0]   disp_q;
  logic                  ovf_q, done_q;
  logic [PRE_W-1:0]      pre_q, pre_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DIGITS-1:0]     blank;
  logic                  lead_zero;
  logic [3:0]            cur_nib;
  logic [6:0]            seg_raw;
  logic [DIGITS-1:0]     anod_q;
  logic [7:0]            cat_q;

  // Out-of-range select values fall through to channel 0
  always_comb begin
    chan_val = data_in[IN_W-1:0];
    for (int k = 1; k < CHANNELS; k++) begin
      if (int'(sel) == k) chan_val = data_in[k*IN_W +: IN_W];
    end
  end

  bcd_dabble_seq #(
    .IN_W   (IN_W),
    .DIGITS (DIGITS)
  ) u_dabble (
    .clk     (clk),
    .reset   (reset),
    .start_i (1'b1),
    .value_i (chan_val),
    .busy_o  (dab_busy),
    .done_o  (dab_done),
    .bcd_o   (dab_bcd),
    .ovf_o   (dab_ovf)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp_q <= '0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= dab_done;
      if (dab_done) begin
        disp_q <= dab_bcd;
        ovf_q  <= dab_ovf;
      end
    end
  end

  always_comb begin
    pre_d = pre_q + 1'b1;
    idx_d = idx_q;
    if (pre_q == PRE_W'(REFRESH_DIV - 1)) begin
      pre_d = '0;
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  // A digit is blank when it and every digit above it are zero; digit 0 always shows
  always_comb begin
    lead_zero = 1'b1;
    blank     = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      lead_zero = lead_zero & (disp_q[4*i +: 4] == 4'd0);
      if ((BLANK_LZ != 0) && (i != 0) && lead_zero) blank[i] = 1'b1;
    end
  end

  always_comb begin
    cur_nib = disp_q[4*int'(idx_q) +: 4];
    if (ovf_q)             seg_raw = SEG_DASH;
    else if (blank[idx_q]) seg_raw = SEG_BLANK;
    else                   seg_raw = nibble_to_seg(cur_nib);
  end

  // anod and cat share one register stage so digit and pattern switch together
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q  <= '0;
      idx_q  <= '0;
      anod_q <= ANOD_INV;
      cat_q  <= CAT_INV;
    end else begin
      pre_q  <= pre_d;
      idx_q  <= idx_d;
      anod_q <= ANOD_INV ^ (DIGITS'(1) << idx_q);
      cat_q  <= CAT_INV ^ {dp_mask[idx_q], seg_raw};
    end
  end

  assign busy      = dab_busy;
  assign conv_done = done_q;
  assign ovf       = ovf_q;
  assign anod      = anod_q;
  assign cat       = cat_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - directed self-checking bench for seg7_scan_driver
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] data_in;
  logic        sel;
  logic [3:0]  dp_mask;
  logic [2:0]  dp_mask_c;

  logic       busy_a, done_a, ovf_a, busy_b, done_b, ovf_b;
  logic       busy_c, done_c, ovf_c, busy_d, done_d, ovf_d;
  logic [3:0] anod_a, anod_b, anod_d;
  logic [2:0] anod_c;
  logic [7:0] cat_a, cat_b, cat_c, cat_d;

  logic [7:0] seen_a [4];
  logic [7:0] seen_b [4];
  logic [7:0] seen_c [3];
  logic [7:0] seen_d [4];
  logic [3:0] m4;
  logic [2:0] m3;
  logic [3:0] seq [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};

  int checks = 0;
  int errors = 0;
  int n;
  logic [3:0] cur;

  always #5 clk = ~clk;

  seg7_scan_driver #(.REFRESH_DIV(4)) u_a (
    .clk(clk), .reset(reset), .data_in(data_in), .sel(sel), .dp_mask(dp_mask),
    .busy(busy_a), .conv_done(done_a), .ovf(ovf_a), .anod(anod_a), .cat(cat_a));

  seg7_scan_driver #(.REFRESH_DIV(4), .BLANK_LZ(0)) u_b (
    .clk(clk), .reset(reset), .data_in(data_in), .sel(sel), .dp_mask(dp_mask),
    .busy(busy_b), .conv_done(done_b), .ovf(ovf_b), .anod(anod_b), .cat(cat_b));

  seg7_scan_driver #(.REFRESH_DIV(4), .DIGITS(3)) u_c (
    .clk(clk), .reset(reset), .data_in(data_in), .sel(sel), .dp_mask(dp_mask_c),
    .busy(busy_c), .conv_done(done_c), .ovf(ovf_c), .anod(anod_c), .cat(cat_c));

  seg7_scan_driver #(.REFRESH_DIV(4), .ACTIVE_LOW(0)) u_d (
    .clk(clk), .reset(reset), .data_in(data_in), .sel(sel), .dp_mask(dp_mask),
    .busy(busy_d), .conv_done(done_d), .ovf(ovf_d), .anod(anod_d), .cat(cat_d));

  // Latest cathode pattern observed for each lit digit
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      m4 = 4'(1 << i);
      if (anod_a == ~m4) seen_a[i] = cat_a;
      if (anod_b == ~m4) seen_b[i] = cat_b;
      if (anod_d == m4)  seen_d[i] = cat_d;
    end
    for (int i = 0; i < 3; i++) begin
      m3 = 3'(1 << i);
      if (anod_c == ~m3) seen_c[i] = cat_c;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input int v);
    case (v)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F;  default: return 7'h00;
    endcase
  endfunction

  function automatic logic [7:0] exp_digit(input int v, input int d, input bit blz, input bit al);
    int p;
    logic [7:0] r;
    p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    if (blz && d > 0 && v < p) r = 8'h00;
    else r = {1'b0, seg_of((v / p) % 10)};
    return al ? ~r : r;
  endfunction

  task automatic settle();
    repeat (60) @(negedge clk);
  endtask

  task automatic check_value(input int v);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("a_v%0d_d%0d", v, i), 32'(seen_a[i]), 32'(exp_digit(v, i, 1'b1, 1'b1)));
      chk($sformatf("b_v%0d_d%0d", v, i), 32'(seen_b[i]), 32'(exp_digit(v, i, 1'b0, 1'b1)));
      chk($sformatf("d_v%0d_d%0d", v, i), 32'(seen_d[i]), 32'(exp_digit(v, i, 1'b1, 1'b0)));
    end
  endtask

  task automatic wait_done_a();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done_a && k < 50);
    if (!done_a) chk("done_timeout", 32'(done_a), 32'd1);
  endtask

  initial begin
    reset = 1'b1; data_in = '0; sel = 1'b0; dp_mask = '0; dp_mask_c = '0;
    repeat (3) @(negedge clk);
    chk("rst_anod_a", 32'(anod_a), 32'hF);
    chk("rst_cat_a",  32'(cat_a),  32'hFF);
    chk("rst_busy_a", 32'(busy_a), 32'd0);
    chk("rst_done_a", 32'(done_a), 32'd0);
    chk("rst_ovf_a",  32'(ovf_a),  32'd0);
    chk("rst_anod_d", 32'(anod_d), 32'h0);
    chk("rst_cat_d",  32'(cat_d),  32'h00);

    reset = 1'b0;
    @(posedge clk); #1;
    chk("rel_anod_a", 32'(anod_a), 32'b1110);
    chk("rel_cat_a",  32'(cat_a),  32'hC0);
    chk("rel_anod_d", 32'(anod_d), 32'b0001);
    chk("rel_busy_a", 32'(busy_a), 32'd1);

    data_in = {10'd0, 10'd1023};
    settle();
    check_value(1023);
    chk("fs_ovf_a", 32'(ovf_a), 32'd0);
    wait_done_a();
    @(negedge clk);
    chk("done_pulse", 32'(done_a), 32'd0);
    n = 1;
    while (!done_a && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("conv_period", 32'(n), 32'd12);

    data_in = {10'd0, 10'd7};
    settle();
    check_value(7);
    data_in = {10'd0, 10'd0};
    settle();
    check_value(0);

    data_in = {10'd0, 10'd1000};
    settle();
    for (int i = 0; i < 3; i++) chk($sformatf("c_dash_d%0d", i), 32'(seen_c[i]), 32'hBF);
    chk("c_ovf_set", 32'(ovf_c), 32'd1);
    check_value(1000);
    data_in = {10'd0, 10'd999};
    settle();
    for (int i = 0; i < 3; i++) chk($sformatf("c_999_d%0d", i), 32'(seen_c[i]), 32'h90);
    chk("c_ovf_clr", 32'(ovf_c), 32'd0);
    check_value(999);

    data_in = {10'd482, 10'd250};
    sel = 1'b0;
    settle();
    wait_done_a();
    @(negedge clk);
    chk("sw_busy", 32'(busy_a), 32'd1);
    sel = 1'b1;
    wait_done_a();
    chk("sw_first",  32'(u_a.disp_q), 32'h0250);
    wait_done_a();
    chk("sw_second", 32'(u_a.disp_q), 32'h0482);

    dp_mask = 4'b0100;
    n = 0;
    while (anod_a != 4'b0111 && n < 40) begin @(negedge clk); n++; end
    n = 0;
    while (anod_a == 4'b0111 && n < 40) begin @(negedge clk); n++; end
    for (int p = 0; p < 5; p++) begin
      chk($sformatf("scan_anod%0d", p), 32'(anod_a), 32'(seq[p]));
      if (p < 4) begin
        n = 0;
        cur = anod_a;
        while (anod_a == cur && n < 10) begin @(negedge clk); n++; end
        chk($sformatf("scan_hold%0d", p), 32'(n), 32'd4);
      end
    end
    repeat (20) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("dp_a_d%0d", i), 32'(seen_a[i][7]), (i == 2) ? 32'd0 : 32'd1);
      chk($sformatf("dp_d_d%0d", i), 32'(seen_d[i][7]), (i == 2) ? 32'd1 : 32'd0);
    end

    dp_mask = 4'b0000;
    sel = 1'b0;
    data_in = {10'd0, 10'd1000};
    settle();
    chk("pre_rst_ovf_c", 32'(ovf_c), 32'd1);
    wait_done_a();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_anod_a", 32'(anod_a), 32'hF);
    chk("mid_cat_a",  32'(cat_a),  32'hFF);
    chk("mid_busy_a", 32'(busy_a), 32'd0);
    chk("mid_done_a", 32'(done_a), 32'd0);
    chk("mid_ovf_c",  32'(ovf_c),  32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("mid_rel_anod_a", 32'(anod_a), 32'b1110);
    chk("mid_rel_cat_a",  32'(cat_a),  32'hC0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
